port_uart_tx: RTL and testbench
===============================

# port_uart_tx

Byte-wide UART transmitter with an input FIFO, placed directly downstream of the processor's memory-mapped output port. The port write strobe and data byte (the `PortSel & MemWrite` strobe and `WriteData[7:0]`) push bytes into the FIFO. The block serializes them as asynchronous 8N1 frames on `tx`. It also returns an 8-bit status byte that the input port can read back, so software can poll for free space and overrun.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥ 2
- CLKS_PER_BIT, 16: clock cycles per serial bit; ≥ 2

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- wr_en  input  1  push strobe from the output-port write decode
- wr_data  input  8  byte to transmit
- clr_ovf  input  1  clears the sticky overrun flag
- tx  output  1  serial line; idles high
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- busy  output  1  a frame is being shifted out (state ≠ IDLE)
- status  output  8  {4'b0, ovf, busy, full, empty}

## Operation
- FIFO pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits, wrapping modulo 2·DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low bits are equal.
- Push, when wr_en=1:
  - If full=0, write wr_data to mem[wr_ptr] and increment wr_ptr.
  - If full=1, drop the byte and set ovf.
  - full is the pre-edge value. A write while full is dropped even when a pop happens in the same cycle.
- Pop: performed only by the FSM, and only when empty=0. A push and a pop in the same cycle are both performed, so the count is unchanged.
- ovf is sticky. clr_ovf=1 clears it. If a set and clr_ovf occur in the same cycle, set wins.
- FSM states:
  - IDLE: tx=1. If empty=0, pop the head into shift register `sh`, clear bit_cnt and clk_cnt, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = sh[0]. Every CLKS_PER_BIT cycles, shift `sh` right and increment bit_cnt. After 8 bits (LSB first), go to PARITY when PORT_UART_PARITY_EN is defined, otherwise to STOP.
  - PARITY: tx = even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if empty=0, pop the next byte and go straight to START with no idle gap; otherwise go to IDLE.
- clk_cnt counts 0..CLKS_PER_BIT-1 and is sized $clog2(CLKS_PER_BIT). bit_cnt is 3 bits.

## Timing
- Reset (reset=0 at a rising clk edge):
  - Outputs: tx=1, full=0, empty=1, busy=0, ovf=0, status=8'h01.
  - Internal: pointers=0, state=IDLE, counters=0.
  - FIFO contents are not cleared.
- Reset asserted mid-frame aborts the frame: tx=1 from the next edge and the remaining FIFO bytes are discarded.
- Write accepted at edge N:
  - empty falls after edge N.
  - The FSM pops at edge N+1, and tx falls after edge N+1.
  - busy rises after edge N+1.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity. Each bit is exactly CLKS_PER_BIT cycles wide.
- full and empty are registered-pointer compares: valid from the edge after the push or pop.
- tx is a registered output with no combinational path from the inputs.
- With back-to-back frames, the next start bit begins in the cycle immediately after the last stop-bit cycle.

## Configuration
- PORT_UART_PARITY_EN:
  - Defined: the PARITY state is present and each frame carries an even-parity bit (8E1).
  - Undefined: the PARITY state and its logic are compiled out (8N1).
- status is identical in both builds.

## Structure
- Shared package `port_uart_pkg`:
  - State enum typedef (IDLE, START, DATA, PARITY, STOP).
  - Status bit-index localparams (EMPTY_B=0, FULL_B=1, BUSY_B=2, OVF_B=3).
- One sub-module, `sync_fifo`, parameterized by WIDTH and DEPTH.
  - Interface: push/pop, data in/out, full/empty.
  - Synchronous active-low reset of the pointers.
- The FSM, baud counter, shifter and ovf flag live in the top module.

## Test plan
- Reset, then idle for 100 cycles -> tx=1 throughout and status=8'h01.
- CLKS_PER_BIT=4; write 8'hA5 at edge N -> tx low from N+1 for 4 cycles, then data 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. busy falls 40 cycles after N+1.
- Write 3 bytes in consecutive cycles (8'h01, 8'h02, 8'h03) -> three frames back to back with no idle gap, LSB first, and empty=1 after the third pop.
- Fill with DEPTH+2 writes while the first frame is in flight (byte 0 pops at edge N+1, so the FIFO reaches full on write DEPTH+1) -> full=1; the (DEPTH+2)th write is dropped and ovf=1, status=8'h0E. Then assert clr_ovf -> ovf=0. Asserting clr_ovf together with an overflowing write -> ovf stays 1.
- Assert reset mid-DATA of the second of 4 queued bytes -> tx=1 and status=8'h01 after the edge, and no further frames are sent.
- PORT_UART_PARITY_EN defined; send 8'h07 -> parity bit 1, 11-bit frame. Send 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/port_uart_pkg.sv
// Shared types for the memory-mapped UART transmitter: FSM state encoding,
// status-byte bit positions and a parity helper.
package port_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int unsigned EMPTY_B = 0;
    localparam int unsigned FULL_B  = 1;
    localparam int unsigned BUSY_B  = 2;
    localparam int unsigned OVF_B   = 3;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/port_uart_tx_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty are compares of the
// registered pointers, read data is the combinational head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never cleared; only the pointers reset.
    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/port_uart_tx.sv
// Byte-wide UART transmitter fed from the output-port write strobe, 8N1 by
// default; define PORT_UART_PARITY_EN for 8E1 frames with an even-parity bit.
module port_uart_tx
    import port_uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic [7:0] status
);

    localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic [7:0]    sh;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] clk_cnt;
    logic          ovf;
    logic          bit_end;
    logic          pop;
    logic [7:0]    head;
`ifdef PORT_UART_PARITY_EN
    logic          par;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bit_end = (clk_cnt == CNT_LAST);

    // The last stop-bit cycle pops directly so back-to-back frames have no gap.
    assign pop = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            sh      <= '0;
            bit_cnt <= '0;
            clk_cnt <= '0;
            ovf     <= 1'b0;
`ifdef PORT_UART_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (wr_en && full) ovf <= 1'b1;
            else if (clr_ovf)  ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        sh      <= head;
                        bit_cnt <= '0;
                        clk_cnt <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
`ifdef PORT_UART_PARITY_EN
                        par     <= even_parity(head);
`endif
                    end
                end

                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= DATA;
                        tx      <= sh[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef PORT_UART_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            sh      <= {1'b0, sh[7:1]};
                            tx      <= sh[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

`ifdef PORT_UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= STOP;
                        tx      <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        if (pop) begin
                            sh    <= head;
                            state <= START;
                            tx    <= 1'b0;
`ifdef PORT_UART_PARITY_EN
                            par   <= even_parity(head);
`endif
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        status         = '0;
        status[EMPTY_B] = empty;
        status[FULL_B]  = full;
        status[BUSY_B]  = busy;
        status[OVF_B]   = ovf;
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// Scoreboard bench for port_uart_tx: stimulus queues expected frames, a line
// monitor decodes tx and compares. Honours PORT_UART_PARITY_EN.
module tb_port_uart_tx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CPB   = 4;
`ifdef PORT_UART_PARITY_EN
    localparam int unsigned NB    = 11;
`else
    localparam int unsigned NB    = 10;
`endif
    localparam int unsigned FRAME = NB * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx;
    logic       full;
    logic       empty;
    logic       busy;
    logic [7:0] status;

    exp_t        sb[$];
    int unsigned gap_log[$];
    int unsigned frames_done;
    int unsigned n_checks;
    int unsigned n_fail;

    port_uart_tx #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .tx      (tx),
        .full    (full),
        .empty   (empty),
        .busy    (busy),
        .status  (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input bit accept);
        exp_t e;
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) begin
            e.data = d;
            e.par  = ^d;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < limit) begin
            step();
            n++;
        end
        chk("drain_in_time", (n < limit), 1);
    endtask

    // Line monitor: decodes each frame sample-by-sample on the falling edge.
    initial begin : monitor
        int unsigned   idle;
        logic [NB-1:0] val;
        logic          stable;
        logic          aborted;
        exp_t          e;
        idle        = 0;
        frames_done = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                val     = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    for (int s = 0; s < CPB; s++) begin
                        if (!(b == 0 && s == 0) && !aborted) begin
                            @(negedge clk);
                            if (reset !== 1'b1) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            if (s == 0) val[b] = tx;
                            else if (tx !== val[b]) stable = 1'b0;
                        end
                    end
                end
                if (!aborted) begin
                    gap_log.push_back(idle);
                    frames_done++;
                    chk("bit_stable", stable, 1);
                    chk("stop_bit", val[NB-1], 1);
                    chk("sb_nonempty", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("frame_data", val[8:1], e.data);
`ifdef PORT_UART_PARITY_EN
                        chk("parity_bit", val[9], e.par);
`endif
                    end
                end
                idle = 0;
            end else begin
                idle++;
            end
        end
    end

    initial begin : stimulus
        int unsigned fd;
        logic        tx_ok;
        logic        st_ok;
        exp_t        e;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        clr_ovf  = 1'b0;
        repeat (3) step();
        chk("reset_tx", tx, 1);
        chk("reset_status", status, 8'h01);
        reset = 1'b1;

        // Idle line.
        tx_ok = 1'b1;
        st_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1) tx_ok = 1'b0;
            if (status !== 8'h01) st_ok = 1'b0;
        end
        chk("idle_tx_high", tx_ok, 1);
        chk("idle_status", st_ok, 1);

        // Single byte 0xA5: latency and frame length.
        put(8'hA5, 1);
        step();
        wr_en = 1'b0;
        chk("a5_empty_after_push", empty, 0);
        chk("a5_tx_before_pop", tx, 1);
        chk("a5_busy_before_pop", busy, 0);
        step();
        chk("a5_tx_start", tx, 0);
        chk("a5_busy_rise", busy, 1);
        chk("a5_empty_after_pop", empty, 1);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            if (k == CPB - 1)   chk("a5_start_width", tx, 0);
            if (k == CPB)       chk("a5_bit0", tx, 1);
            if (k == 2 * CPB)   chk("a5_bit1", tx, 0);
            if (k == FRAME - 1) chk("a5_busy_last", busy, 1);
            if (k == FRAME)     chk("a5_busy_fall", busy, 0);
        end
        drain(50);

        // Three bytes back to back.
        gap_log.delete();
        put(8'h01, 1);
        step();
        put(8'h02, 1);
        step();
        put(8'h03, 1);
        step();
        wr_en = 1'b0;
        for (int j = 1; j <= 2 * FRAME - 1; j++) begin
            step();
            if (j == 2 * FRAME - 2) chk("b2b_empty_before_pop3", empty, 0);
            if (j == 2 * FRAME - 1) chk("b2b_empty_after_pop3", empty, 1);
        end
        drain(3 * FRAME);
        chk("b2b_frame_count", gap_log.size(), 3);
        if (gap_log.size() == 3) begin
            chk("b2b_gap1", gap_log[1], 0);
            chk("b2b_gap2", gap_log[2], 0);
        end

        // Overflow: byte 0 pops at once, write DEPTH+1 fills, DEPTH+2 dropped.
        for (int k = 0; k < DEPTH + 2; k++) begin
            put(8'h10 + 8'(k), (k <= DEPTH));
            step();
        end
        wr_en = 1'b0;
        chk("ovf_full", full, 1);
        chk("ovf_status", status, 8'h0E);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clear", status, 8'h06);
        clr_ovf = 1'b1;
        put(8'hEE, 0);
        step();
        clr_ovf = 1'b0;
        wr_en   = 1'b0;
        chk("ovf_set_wins", status, 8'h0E);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clear2", status, 8'h06);
        drain((DEPTH + 1) * FRAME + 100);
        chk("ovf_drained_status", status, 8'h01);

        // Reset in the middle of the second of four frames.
        put(8'h3C, 1);
        step();
        put(8'hC3, 1);
        step();
        put(8'h5A, 1);
        step();
        put(8'h96, 1);
        step();
        wr_en = 1'b0;
        repeat (FRAME + CPB + 4) step();
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_sb", sb.size(), 3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_status", status, 8'h01);
        while (sb.size() != 0) e = sb.pop_front();
        fd    = frames_done;
        tx_ok = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step();
            if (tx !== 1'b1) tx_ok = 1'b0;
        end
        chk("rst_no_more_tx", tx_ok, 1);
        chk("rst_no_more_frames", frames_done, fd);
        chk("rst_status_idle", status, 8'h01);

`ifdef PORT_UART_PARITY_EN
        // Parity: 0x07 has three ones, 0x03 has two.
        e.data = 8'h07;
        e.par  = 1'b1;
        sb.push_back(e);
        wr_en   = 1'b1;
        wr_data = 8'h07;
        step();
        wr_en = 1'b0;
        drain(2 * FRAME);
        e.data = 8'h03;
        e.par  = 1'b0;
        sb.push_back(e);
        wr_en   = 1'b1;
        wr_data = 8'h03;
        step();
        wr_en = 1'b0;
        drain(2 * FRAME);
`endif

        chk("sb_empty_at_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
